// File: rtl/cnt_pkg.sv
// Shared counter definitions: count width, count type and the wrap value helper.
// Used by the synchronous counter and the compare/PWM stage.
package cnt_pkg;

    localparam int CNT_W = 4;

    typedef logic [CNT_W-1:0] cnt_t;

    // Largest count value representable in w bits (the value just before a wrap).
    function automatic int unsigned cnt_max(input int unsigned w);
        return (32'd1 << w) - 32'd1;
    endfunction

endpackage

// File: rtl/cnt_wrap_detect.sv
// Tracks the previous count and flags a genuine MAX->0 wrap and any change of count.
// Jumps into 0 from other values (upstream reset) are deliberately not wraps.
module cnt_wrap_detect
    import cnt_pkg::*;
#(
    parameter int WIDTH = CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] cnt_i,
    output logic             wrap_o,
    output logic             changed_o
);

    localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(cnt_max(WIDTH));

    logic [WIDTH-1:0] prev_cnt_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_cnt_q <= '0;
        end else begin
            prev_cnt_q <= cnt_i;
        end
    end

    assign wrap_o    = (prev_cnt_q == CNT_MAX) && (cnt_i == '0);
    assign changed_o = (cnt_i != prev_cnt_q);

endmodule

// File: rtl/cnt_compare_pwm.sv
// Compare/PWM stage: duty written through a valid/ready shadow register and
// committed only on counter wrap, so the PWM never glitches mid-period.
module cnt_compare_pwm
    import cnt_pkg::*;
#(
    parameter int               WIDTH   = CNT_W,
    parameter logic [WIDTH-1:0] CMP_RST = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] cnt_in,
    input  logic             cmp_wr,
    input  logic [WIDTH-1:0] cmp_data,
    output logic             cmp_ready,
    output logic             pwm_out,
    output logic             match_pulse,
    output logic             wrap_pulse
);

    logic [WIDTH-1:0] active_q, active_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic             pending_q, pending_d;
    logic             pwm_q, pwm_d;
    logic             match_q, match_d;
    logic             wrap_q;

    logic             wrap;
    logic             changed;
    logic             accept;
    logic             commit;

    cnt_wrap_detect #(
        .WIDTH (WIDTH)
    ) u_wrap_detect (
        .clk       (clk),
        .rst       (rst),
        .cnt_i     (cnt_in),
        .wrap_o    (wrap),
        .changed_o (changed)
    );

    // Accept needs pending=0 and commit needs pending=1, so they never coincide:
    // a write landing on a wrap is held in shadow until the following wrap.
    assign accept = cmp_wr && !pending_q;
    assign commit = wrap && pending_q;

    // NOTE: every signal gets a default at the top of always_comb so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        active_d  = active_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;

        if (accept) begin
            shadow_d  = cmp_data;
            pending_d = 1'b1;
        end else if (commit) begin
            active_d  = shadow_q;
            pending_d = 1'b0;
        end

        // Outputs compare against the post-commit value so the new duty applies from count 0.
        pwm_d   = (cnt_in < active_d);
        match_d = (cnt_in == active_d) && changed;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            active_q  <= CMP_RST;
            shadow_q  <= CMP_RST;
            pending_q <= 1'b0;
            pwm_q     <= 1'b0;
            match_q   <= 1'b0;
            wrap_q    <= 1'b0;
        end else begin
            active_q  <= active_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
            pwm_q     <= pwm_d;
            match_q   <= match_d;
            wrap_q    <= wrap;
        end
    end

    assign cmp_ready   = ~pending_q;
    assign pwm_out     = pwm_q;
    assign match_pulse = match_q;
    assign wrap_pulse  = wrap_q;

endmodule

// File: tb/tb_cnt_compare_pwm.sv
// Directed bench for cnt_compare_pwm: free-running 0..15 count with per-period
// hand-computed bit vectors (bit c = expected value after count c is applied).
module tb_cnt_compare_pwm;
    import cnt_pkg::*;

    logic clk;
    logic rst;
    cnt_t cnt_in;
    logic cmp_wr;
    cnt_t cmp_data;
    logic cmp_ready;
    logic pwm_out;
    logic match_pulse;
    logic wrap_pulse;

    int total;
    int bad;

    cnt_compare_pwm #(
        .WIDTH   (4),
        .CMP_RST (4'd0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cnt_in      (cnt_in),
        .cmp_wr      (cmp_wr),
        .cmp_data    (cmp_data),
        .cmp_ready   (cmp_ready),
        .pwm_out     (pwm_out),
        .match_pulse (match_pulse),
        .wrap_pulse  (wrap_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Apply one count (and optional write), clock it in, then settle past the edge.
    task automatic tick(input int c, input logic wr, input int data);
        cnt_in   = 4'(c);
        cmp_wr   = wr;
        cmp_data = 4'(data);
        @(posedge clk);
        #1;
        cmp_wr   = 1'b0;
    endtask

    // One full period 0..15 with up to two writes; wr_at = -1 means no write.
    task automatic run_period(input string name,
                              input logic [15:0] pwm_v,
                              input logic [15:0] match_v,
                              input logic [15:0] wrap_v,
                              input logic [15:0] rdy_v,
                              input int wr_at1, input int d1,
                              input int wr_at2, input int d2);
        for (int c = 0; c < 16; c++) begin
            if (c == wr_at1)      tick(c, 1'b1, d1);
            else if (c == wr_at2) tick(c, 1'b1, d2);
            else                  tick(c, 1'b0, 0);
            check($sformatf("%s pwm c=%0d", name, c),   int'(pwm_out),     int'(pwm_v[c]));
            check($sformatf("%s match c=%0d", name, c), int'(match_pulse), int'(match_v[c]));
            check($sformatf("%s wrap c=%0d", name, c),  int'(wrap_pulse),  int'(wrap_v[c]));
            check($sformatf("%s ready c=%0d", name, c), int'(cmp_ready),   int'(rdy_v[c]));
        end
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        rst      = 1'b0;
        cnt_in   = '0;
        cmp_wr   = 1'b0;
        cmp_data = '0;

        // 1. Reset held for 3 clocks
        repeat (3) @(posedge clk);
        #1;
        check("rst pwm",   int'(pwm_out),     0);
        check("rst match", int'(match_pulse), 0);
        check("rst wrap",  int'(wrap_pulse),  0);
        check("rst ready", int'(cmp_ready),   1);
        rst = 1'b1;

        // active=0, prev=0 at the first 0: no wrap, no match
        run_period("p0", 16'h0000, 16'h0000, 16'h0000, 16'hFFFF, -1, 0, -1, 0);

        // 2./3. write 5 at count 3, write 9 at count 10 is ignored (pending)
        run_period("p1", 16'h0000, 16'h0001, 16'h0001, 16'h0007, 3, 5, 10, 9);

        // 5 committed at this wrap
        run_period("p2", 16'h001F, 16'h0020, 16'h0001, 16'hFFFF, -1, 0, -1, 0);

        // 4. write 12 on the wrap cycle: accepted, not committed yet
        run_period("p3", 16'h001F, 16'h0020, 16'h0001, 16'h0000, 0, 12, -1, 0);

        // 12 active; 5. write 0 at count 2
        run_period("p4", 16'h0FFF, 16'h1000, 16'h0001, 16'h0003, 2, 0, -1, 0);

        // duty 0: pwm stuck low, match at count 0; write 15 at count 4
        run_period("p5", 16'h0000, 16'h0001, 16'h0001, 16'h000F, 4, 15, -1, 0);

        // duty 15: high 15 of 16 counts
        run_period("p6", 16'h7FFF, 16'h8000, 16'h0001, 16'hFFFF, -1, 0, -1, 0);

        // stalled count: no repeated match, no wrap
        tick(0, 1'b0, 0);
        tick(0, 1'b0, 0);
        check("stall wrap",  int'(wrap_pulse),  0);
        check("stall match", int'(match_pulse), 0);
        check("stall pwm",   int'(pwm_out),     1);

        // 6. pending write of 7 at count 3, reset at count 8
        for (int c = 1; c <= 8; c++) begin
            tick(c, (c == 3), 7);
            check($sformatf("p7 pwm c=%0d", c),   int'(pwm_out),   1);
            check($sformatf("p7 ready c=%0d", c), int'(cmp_ready), (c < 3) ? 1 : 0);
        end
        rst = 1'b0;
        #1;
        check("mid rst pwm",   int'(pwm_out),     0);
        check("mid rst match", int'(match_pulse), 0);
        check("mid rst wrap",  int'(wrap_pulse),  0);
        check("mid rst ready", int'(cmp_ready),   1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;

        // restart at 0 after reset: 8->0 is not a wrap, active back to 0
        run_period("p8", 16'h0000, 16'h0000, 16'h0000, 16'hFFFF, -1, 0, -1, 0);
        // pending 7 was lost: duty stays 0 across the first real wrap
        run_period("p9", 16'h0000, 16'h0001, 16'h0001, 16'hFFFF, -1, 0, -1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
